// File: rtl/chnl_pkg.sv
// Definitions shared by the Riffa CHNL receive and transmit blocks: channel FSM
// states, PCIe word-size constants and the transfer length to beat count helper.
package chnl_pkg;
    localparam int PCI_WORD_W = 32;
    localparam int PCI_LEN_W  = 32;
    localparam int PCI_OFF_W  = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_RECV,
        S_DONE
    } chnl_state_e;

    // ceil(len*32 / data_w); data_w is a multiple of 32, so divide in word units.
    // 33 bits keep len + words_per_beat - 1 from wrapping.
    function automatic logic [32:0] beats_from_len(input logic [PCI_LEN_W-1:0] len,
                                                   input int unsigned data_w);
        logic [32:0] per_beat;
        per_beat = 33'(data_w / PCI_WORD_W);
        return ({1'b0, len} + per_beat - 33'd1) / per_beat;
    endfunction
endpackage

// File: rtl/chnl_rx_if.sv
// Riffa RX channel plus the repacked output stream of chnl_rx.
// slave: the receiver block; master: the host/consumer side.
interface chnl_rx_if #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32
);
    import chnl_pkg::*;

    logic                        CHNL_RX_CLK;
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [PCI_LEN_W-1:0]        CHNL_RX_LEN;
    logic [PCI_OFF_W-1:0]        CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;
    logic                        o_val;
    logic                        o_rdy;
    logic [RX_WIDTH-1:0]         o_data;

    modport slave (
        output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN, o_val, o_data,
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID, o_rdy
    );

    modport master (
        input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN, o_val, o_data,
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
               CHNL_RX_DATA, CHNL_RX_DATA_VALID, o_rdy
    );
endinterface

// File: rtl/fifo.sv
// Show-ahead val/rdy FIFO; a pushed entry is visible on out_* the next cycle.
// DEPTH must be a power of two.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push, pop;

    assign in_rdy   = count_reg != (AW+1)'(DEPTH);
    assign out_val  = count_reg != '0;
    assign out_data = mem[rd_ptr_reg];
    assign push     = in_val && in_rdy;
    assign pop      = out_val && out_rdy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_reg] <= in_data;
    end
endmodule

// File: rtl/repacker.sv
// Width converter over a continuous stream of W-bit units: IN units per input
// word, OUT units per output word, lowest unit first.
module repacker #(
    parameter int IN  = 1,
    parameter int OUT = 1,
    parameter int W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [IN*W-1:0]  in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [OUT*W-1:0] out_data
);
    localparam int UNITS = IN + OUT;
    localparam int FW    = $clog2(UNITS + 1);

    logic [UNITS*W-1:0] pack_reg, pack_next;
    logic [FW-1:0]      fill_reg, fill_next, kept;
    logic               push, pop;

    // Accepting only while fill <= OUT keeps in_rdy independent of out_rdy and
    // leaves the low OUT units untouched while an output word is stalled.
    assign out_val  = fill_reg >= FW'(OUT);
    assign in_rdy   = fill_reg <= FW'(OUT);
    assign out_data = pack_reg[OUT*W-1:0];
    assign push     = in_val && in_rdy;
    assign pop      = out_val && out_rdy;

    always_comb begin
        pack_next = pack_reg;
        kept      = fill_reg;
        if (pop) begin
            pack_next = pack_reg >> (OUT*W);
            kept      = fill_reg - FW'(OUT);
        end
        fill_next = kept;
        if (push) begin
            pack_next = pack_next | ({{(OUT*W){1'b0}}, in_data} << (kept * W));
            fill_next = kept + FW'(IN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_reg <= '0;
            fill_reg <= '0;
        end else begin
            pack_reg <= pack_next;
            fill_reg <= fill_next;
        end
    end
endmodule

// File: rtl/chnl_rx.sv
// Buffered Riffa CHNL receiver: acks one host transfer at a time, queues its beats
// and repacks them onto a val/rdy stream. Optional CHNL_RX_ABORT_EN adds host abort.
module chnl_rx #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int GCD              = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
`ifdef CHNL_RX_ABORT_EN
    output logic      o_abort,
`endif
    chnl_rx_if.slave  bus
);
    import chnl_pkg::*;

    chnl_state_e                 state_reg, state_next;
    logic [32:0]                 cnt_left_reg, cnt_left_next;
    logic                        fifo_in_rdy, accept, ren;
    logic                        fifo_out_val, fifo_out_rdy;
    logic [C_PCI_DATA_WIDTH-1:0] fifo_out_data;
    logic                        unused_ok;

    assign bus.CHNL_RX_CLK      = clk_i;
    assign bus.CHNL_RX_ACK      = state_reg == S_ACK;
    assign ren                  = (state_reg == S_RECV) && fifo_in_rdy;
    assign bus.CHNL_RX_DATA_REN = ren;
    assign accept               = ren && bus.CHNL_RX_DATA_VALID;
    assign unused_ok            = ^{bus.CHNL_RX_LAST, bus.CHNL_RX_OFF};

`ifdef CHNL_RX_ABORT_EN
    logic abort_set, abort_reg;
    assign o_abort = abort_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        abort_reg <= 1'b0;
        else if (abort_set) abort_reg <= 1'b1;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            cnt_left_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_left_reg <= cnt_left_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_left_next = cnt_left_reg;
`ifdef CHNL_RX_ABORT_EN
        abort_set     = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (bus.CHNL_RX) begin
                    cnt_left_next = beats_from_len(bus.CHNL_RX_LEN, C_PCI_DATA_WIDTH);
                    state_next    = S_ACK;
                end
            end
            S_ACK: begin
                state_next = (cnt_left_reg != '0) ? S_RECV : S_DONE;
            end
            S_RECV: begin
                if (accept) begin
                    cnt_left_next = cnt_left_reg - 33'd1;
                    if (cnt_left_reg == 33'd1) state_next = S_DONE;
                end
`ifdef CHNL_RX_ABORT_EN
                // A final accept coinciding with CHNL_RX low completes normally.
                if (!bus.CHNL_RX && cnt_left_next != '0) begin
                    state_next    = S_IDLE;
                    cnt_left_next = '0;
                    abort_set     = 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (!bus.CHNL_RX) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    fifo #(
        .WIDTH (C_PCI_DATA_WIDTH),
        .DEPTH (16)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_val   (accept),
        .in_rdy   (fifo_in_rdy),
        .in_data  (bus.CHNL_RX_DATA),
        .out_val  (fifo_out_val),
        .out_rdy  (fifo_out_rdy),
        .out_data (fifo_out_data)
    );

    repacker #(
        .IN  (C_PCI_DATA_WIDTH / GCD),
        .OUT (RX_WIDTH / GCD),
        .W   (GCD)
    ) u_repacker (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .in_val   (fifo_out_val),
        .in_rdy   (fifo_out_rdy),
        .in_data  (fifo_out_data),
        .out_val  (bus.o_val),
        .out_rdy  (bus.o_rdy),
        .out_data (bus.o_data)
    );
endmodule

// File: tb/tb_chnl_rx.sv
// Randomized bench for chnl_rx (64-bit beats repacked to 96-bit words): the host
// driver pushes every accepted 32-bit word into a queue, an output monitor pops.
module tb_chnl_rx;
    localparam int CW  = 64;
    localparam int RW  = 96;
    localparam int WPB = CW / 32;
    localparam int WPO = RW / 32;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    chnl_rx_if #(.C_PCI_DATA_WIDTH(CW), .RX_WIDTH(RW)) bus ();

`ifdef CHNL_RX_ABORT_EN
    logic o_abort;
`endif

    chnl_rx #(
        .C_PCI_DATA_WIDTH (CW),
        .RX_WIDTH         (RW),
        .GCD              (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
`ifdef CHNL_RX_ABORT_EN
        .o_abort(o_abort),
`endif
        .bus    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          beats_sent = 0;
    bit          xfer_killed = 0;
    int          rdy_mode = 1;
    int          first_acc = -1;
    int          last_acc = -1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Consumer ready: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        bus.o_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.o_rdy = (rdy_mode == 2) ? 1'($urandom_range(1)) : (rdy_mode == 1);
        end
    end

    // Output monitor: every accepted output word is the next WPO words of the stream.
    initial begin
        logic [RW-1:0] held;
        logic [RW-1:0] want;
        bit            hold_pending;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) check("o_data_stable", bus.o_data, held);
                if (bus.o_val && bus.o_rdy) begin
                    if (exp_q.size() < WPO) begin
                        check("word_underflow", exp_q.size(), WPO);
                    end else begin
                        for (int i = 0; i < WPO; i++) want[i*32 +: 32] = exp_q.pop_front();
                        check("o_data", bus.o_data, want);
                        $display("word %0h", bus.o_data);
                    end
                end
                hold_pending = bus.o_val && !bus.o_rdy;
                held = bus.o_data;
            end
        end
    end

    // One host transfer. vprob: VALID probability in percent; hold: extra cycles
    // CHNL_RX stays high after the last beat; drop_after: lower CHNL_RX once that
    // many beats are accepted (-1 = never).
    task automatic do_xfer(input int len, input int vprob, input int hold, input int drop_after);
        int beats, acks, ack_cyc, cyc, want_beats;
        bit early_ren, aborted, dropped;
        logic [CW-1:0] beat;
        beats = (len + WPB - 1) / WPB;
        acks = 0; ack_cyc = -1; cyc = 0;
        early_ren = 0; aborted = 0; dropped = 0;
        beats_sent = 0; xfer_killed = 0; first_acc = -1; last_acc = -1;
        beat = {$urandom, $urandom};
        @(posedge clk);
        #1;
        bus.CHNL_RX = 1'b1;
        bus.CHNL_RX_LEN = 32'(len);
        bus.CHNL_RX_DATA = beat;
        bus.CHNL_RX_DATA_VALID = ($urandom_range(99) < vprob);
        while (!(acks > 0 && beats_sent == beats) && !aborted && cyc < 3000) begin
            @(negedge clk);
            if (!rst_ni) begin
                xfer_killed = 1;
                break;
            end
            if (bus.CHNL_RX_ACK) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = cyc;
            end
            if (bus.CHNL_RX_DATA_REN && acks == 0) early_ren = 1;
            if (bus.CHNL_RX_DATA_REN && bus.CHNL_RX_DATA_VALID) begin
                for (int i = 0; i < WPB; i++) exp_q.push_back(beat[i*32 +: 32]);
                beats_sent++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                beat = {$urandom, $urandom};
            end
            cyc++;
            @(posedge clk);
            #1;
            bus.CHNL_RX_DATA = beat;
            bus.CHNL_RX_DATA_VALID = ($urandom_range(99) < vprob);
            if (drop_after >= 0 && beats_sent == drop_after && !dropped) begin
                dropped = 1;
                bus.CHNL_RX = 1'b0;
`ifdef CHNL_RX_ABORT_EN
                bus.CHNL_RX_DATA_VALID = 1'b0;
                aborted = 1;
`endif
            end
        end
        if (xfer_killed) begin
            bus.CHNL_RX = 1'b0;
            bus.CHNL_RX_DATA_VALID = 1'b0;
            $display("xfer len=%0d interrupted by reset after %0d beats", len, beats_sent);
            return;
        end
        check("xfer_in_time", cyc < 3000, 1);
        repeat (aborted ? 0 : hold) begin
            @(negedge clk);
            if (bus.CHNL_RX_ACK) acks++;
            if (bus.CHNL_RX_DATA_REN && bus.CHNL_RX_DATA_VALID) beats_sent++;
            @(posedge clk);
            #1;
            bus.CHNL_RX_DATA_VALID = ($urandom_range(99) < vprob);
        end
        bus.CHNL_RX = 1'b0;
        bus.CHNL_RX_DATA_VALID = 1'b0;
        @(negedge clk);
        if (bus.CHNL_RX_ACK) acks++;
`ifdef CHNL_RX_ABORT_EN
        if (aborted) begin
            @(negedge clk);
            check("abort_flag", o_abort, 1);
        end
`endif
        check("ren_after_xfer", bus.CHNL_RX_DATA_REN, 0);
        want_beats = aborted ? drop_after : beats;
        check("ack_count", acks, 1);
        check("ack_latency", ack_cyc, 1);
        check("ren_before_ack", early_ren, 0);
        check("beats_accepted", beats_sent, want_beats);
        $display("xfer len=%0d beats=%0d/%0d acks=%0d%s", len, beats_sent, want_beats, acks,
                 aborted ? " aborted" : "");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 400 && exp_q.size() >= WPO; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_left", exp_q.size() < WPO, 1);
        check("drain_oval", bus.o_val, 0);
    endtask

    initial begin
        bus.CHNL_RX = 1'b0;
        bus.CHNL_RX_LAST = 1'b1;
        bus.CHNL_RX_LEN = '0;
        bus.CHNL_RX_OFF = '0;
        bus.CHNL_RX_DATA = '0;
        bus.CHNL_RX_DATA_VALID = 1'b0;
        #2;
        check("rst_ack", bus.CHNL_RX_ACK, 0);
        check("rst_ren", bus.CHNL_RX_DATA_REN, 0);
        check("rst_oval", bus.o_val, 0);
`ifdef CHNL_RX_ABORT_EN
        check("rst_abort", o_abort, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Full-rate transfer: one beat per cycle once REN rises.
        rdy_mode = 1;
        do_xfer(16, 100, 0, -1);
        check("throughput", last_acc - first_acc, 7);
        // Partial last beat, then residual words completed by later transfers.
        do_xfer(3, 100, 1, -1);
        do_xfer(2, 100, 0, -1);
        do_xfer(1, 100, 0, -1);
        // Zero length with CHNL_RX held: single ACK, no REN.
        do_xfer(0, 100, 5, -1);

        rdy_mode = 2;
        for (int t = 0; t < 25; t++)
            do_xfer($urandom_range(0, 20), $urandom_range(30, 100), $urandom_range(0, 3), -1);
        drain();

        // Consumer stalled for 100 cycles on a 64-word transfer.
        rdy_mode = 0;
        beats_sent = 0;
        fork
            do_xfer(64, 100, 0, -1);
            begin
                repeat (100) @(posedge clk);
                #2;
                check("bp_stalled", beats_sent < 32, 1);
                @(negedge clk);
                check("bp_ren_low", bus.CHNL_RX_DATA_REN, 0);
                rdy_mode = 1;
            end
        join
        drain();

        // CHNL_RX dropped after 2 beats: abort if enabled, otherwise ignored.
        do_xfer(16, 100, 0, 2);
        drain();

        // Reset in the middle of a stalled transfer.
        rdy_mode = 0;
        beats_sent = 0;
        fork
            do_xfer(40, 100, 0, -1);
            begin
                for (int i = 0; i < 200 && beats_sent < 2; i++) @(posedge clk);
                repeat (3) @(posedge clk);
                #3;
                check("pre_reset_oval", bus.o_val, 1);
                rst_ni = 1'b0;
                exp_q.delete();
                #1;
                check("reset_oval", bus.o_val, 0);
                check("reset_ren", bus.CHNL_RX_DATA_REN, 0);
                check("reset_ack", bus.CHNL_RX_ACK, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_ni = 1'b1;
            end
        join
`ifdef CHNL_RX_ABORT_EN
        check("abort_cleared", o_abort, 0);
`endif
        rdy_mode = 1;
        do_xfer(7, 100, 0, -1);
        do_xfer(5, 70, 2, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
